// File: rtl/vfp_src_pkg.sv
// Shared types and default constants for the AXI4-Stream video frame source.
package vfp_src_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LINE   = 2'd1,
        HBLANK = 2'd2
    } src_state_e;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_BARS  = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_e;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_NUM_CH    = 3;
    localparam int DEF_PPB       = 1;
    localparam int DEF_DIM_W     = 16;
    localparam int DEF_BAR_SHIFT = 5;
    localparam int DEF_CHK_SHIFT = 3;

    // Colour-bar index bit that blanks channel ch (R/G/B cycle for >3 channels).
    function automatic int bar_bit(input int ch);
        return ch % 3;
    endfunction

endpackage

// File: rtl/vfp_pattern_pixel.sv
// Combinational colour of one pixel from the selected test pattern and its coordinates.
module vfp_pattern_pixel
    import vfp_src_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DIM_W     = DEF_DIM_W,
    parameter int PX_W      = DEF_DIM_W + 8,
    parameter int BAR_SHIFT = DEF_BAR_SHIFT,
    parameter int CHK_SHIFT = DEF_CHK_SHIFT
) (
    input  logic [1:0]               mode_i,
    input  logic [PX_W-1:0]          px_i,
    input  logic [DIM_W-1:0]         py_i,
    input  logic [DATA_W*NUM_CH-1:0] solid_i,
    output logic [DATA_W*NUM_CH-1:0] pix_o
);

    logic [2:0] bar_idx_s;
    logic       chk_s;

    assign bar_idx_s = 3'(px_i >> BAR_SHIFT);
    assign chk_s     = 1'((px_i >> CHK_SHIFT) ^ (PX_W'(py_i) >> CHK_SHIFT));

    // Per-channel colour selection for the active pattern.
    always_comb begin
        pix_o = {(DATA_W*NUM_CH){1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            case (pattern_e'(mode_i))
                PAT_SOLID: pix_o[c*DATA_W +: DATA_W] = solid_i[c*DATA_W +: DATA_W];
                PAT_RAMP:  pix_o[c*DATA_W +: DATA_W] = px_i[DATA_W-1:0];
                PAT_BARS: begin
                    if (bar_idx_s[bar_bit(c)] == 1'b0) begin
                        pix_o[c*DATA_W +: DATA_W] = {DATA_W{1'b1}};
                    end else begin
                        pix_o[c*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                    end
                end
                PAT_CHECK: begin
                    if (chk_s) begin
                        pix_o[c*DATA_W +: DATA_W] = {DATA_W{1'b1}};
                    end else begin
                        pix_o[c*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                    end
                end
                default:   pix_o[c*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            endcase
        end
    end

endmodule

// File: rtl/vfp_axis_frame_source.sv
// AXI4-Stream video frame generator with programmable geometry, horizontal
// blanking, runtime test patterns and frame statistics.
// Optional: define VFP_FRAME_SUM_EN to add the frame_sum output (32-bit
// modular sum of all beats of the last completed frame).
module vfp_axis_frame_source
    import vfp_src_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int PPB       = DEF_PPB,
    parameter int DIM_W     = DEF_DIM_W,
    parameter int BAR_SHIFT = DEF_BAR_SHIFT,
    parameter int CHK_SHIFT = DEF_CHK_SHIFT
) (
    input  logic                            ACLK,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [1:0]                      mode,
    input  logic [DIM_W-1:0]                h_beats,
    input  logic [DIM_W-1:0]                v_lines,
    input  logic [7:0]                      h_blank,
    input  logic [DATA_W*NUM_CH-1:0]        solid_color,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tvalid,
    output logic [DATA_W*NUM_CH*PPB-1:0]    m_axis_tdata,
    output logic                            m_axis_tuser,
    output logic                            m_axis_tlast,
    output logic                            frame_done,
    output logic [31:0]                     frame_count
`ifdef VFP_FRAME_SUM_EN
    ,
    output logic [31:0]                     frame_sum
`endif
);

    localparam int PIX_W  = DATA_W * NUM_CH;
    localparam int BEAT_W = PIX_W * PPB;
    localparam int PX_W   = DIM_W + 8;

    src_state_e        state_q, state_d;
    logic [DIM_W-1:0]  x_q, x_d, y_q, y_d;
    logic [7:0]        blank_q, blank_d;
    logic [1:0]        mode_q, mode_d;
    logic [DIM_W-1:0]  hb_q, hb_d, vl_q, vl_d;
    logic [7:0]        hbl_q, hbl_d;
    logic [PIX_W-1:0]  solid_q, solid_d;
    logic              tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
    logic [BEAT_W-1:0] tdata_q, tdata_d;
    logic              done_q, done_d;
    logic [31:0]       count_q, count_d;
    logic [BEAT_W-1:0] pattern_s;
    logic              accept_s, start_ok_s, last_x_s, last_y_s, eof_s, launch_s, load_s;

    assign accept_s   = tvalid_q & m_axis_tready;
    assign start_ok_s = enable && (h_beats != {DIM_W{1'b0}}) && (v_lines != {DIM_W{1'b0}});
    assign last_x_s   = (x_q == hb_q - DIM_W'(1));
    assign last_y_s   = (y_q == vl_q - DIM_W'(1));
    assign eof_s      = (state_q == LINE) && accept_s && last_x_s && last_y_s;
    // A frame starts from IDLE or back-to-back right after the previous frame ends.
    assign launch_s   = start_ok_s && ((state_q == IDLE) || eof_s);
    // Output registers may take a new beat unless a presented beat is stalled.
    assign load_s     = !tvalid_q || m_axis_tready;

    // Pixel colours of the beat that will be presented next (coordinates x_d/y_d).
    for (genvar p = 0; p < PPB; p++) begin : g_pix
        logic [PX_W-1:0] px_s;
        assign px_s = PX_W'(x_d) * PX_W'(PPB) + PX_W'(p);
        vfp_pattern_pixel #(
            .DATA_W    (DATA_W),
            .NUM_CH    (NUM_CH),
            .DIM_W     (DIM_W),
            .PX_W      (PX_W),
            .BAR_SHIFT (BAR_SHIFT),
            .CHK_SHIFT (CHK_SHIFT)
        ) u_pix (
            .mode_i  (mode_d),
            .px_i    (px_s),
            .py_i    (y_d),
            .solid_i (solid_d),
            .pix_o   (pattern_s[p*PIX_W +: PIX_W])
        );
    end

    // State, counters, latched frame config and registered stream outputs.
    always_ff @(posedge ACLK or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= {DIM_W{1'b0}};
            y_q      <= {DIM_W{1'b0}};
            blank_q  <= 8'd0;
            mode_q   <= 2'd0;
            hb_q     <= {DIM_W{1'b0}};
            vl_q     <= {DIM_W{1'b0}};
            hbl_q    <= 8'd0;
            solid_q  <= {PIX_W{1'b0}};
            tvalid_q <= 1'b0;
            tdata_q  <= {BEAT_W{1'b0}};
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            blank_q  <= blank_d;
            mode_q   <= mode_d;
            hb_q     <= hb_d;
            vl_q     <= vl_d;
            hbl_q    <= hbl_d;
            solid_q  <= solid_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    // Next state: beat/line walk, blanking countdown, config latch at frame start.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        blank_d = blank_q;
        mode_d  = mode_q;
        hb_d    = hb_q;
        vl_d    = vl_q;
        hbl_d   = hbl_q;
        solid_d = solid_q;
        case (state_q)
            IDLE: state_d = IDLE;
            LINE: begin
                if (accept_s) begin
                    if (!last_x_s) begin
                        x_d = x_q + DIM_W'(1);
                    end else if (last_y_s) begin
                        state_d = IDLE;
                        x_d     = {DIM_W{1'b0}};
                        y_d     = {DIM_W{1'b0}};
                    end else if (hbl_q != 8'd0) begin
                        state_d = HBLANK;
                        blank_d = 8'd0;
                    end else begin
                        x_d = {DIM_W{1'b0}};
                        y_d = y_q + DIM_W'(1);
                    end
                end else begin
                    state_d = LINE;
                end
            end
            HBLANK: begin
                if (blank_q == hbl_q - 8'd1) begin
                    state_d = LINE;
                    x_d     = {DIM_W{1'b0}};
                    y_d     = y_q + DIM_W'(1);
                end else begin
                    blank_d = blank_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (launch_s) begin
            state_d = LINE;
            x_d     = {DIM_W{1'b0}};
            y_d     = {DIM_W{1'b0}};
            mode_d  = mode;
            hb_d    = h_beats;
            vl_d    = v_lines;
            hbl_d   = h_blank;
            solid_d = solid_color;
        end else begin
            mode_d = mode_q;
        end
    end

    // Output next values: hold while stalled, otherwise describe the next beat.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        if (load_s) begin
            tvalid_d = (state_d == LINE);
            tdata_d  = (state_d == LINE) ? pattern_s : {BEAT_W{1'b0}};
            tuser_d  = (state_d == LINE) && (x_d == {DIM_W{1'b0}}) && (y_d == {DIM_W{1'b0}});
            tlast_d  = (state_d == LINE) && (x_d == hb_d - DIM_W'(1));
        end else begin
            tvalid_d = tvalid_q;
        end
        done_d  = eof_s;
        count_d = eof_s ? count_q + 32'd1 : count_q;
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign frame_done    = done_q;
    assign frame_count   = count_q;

`ifdef VFP_FRAME_SUM_EN
    logic [31:0] sum_q, sum_d, fsum_q, fsum_d;

    // Running beat sum restarted at the first beat; snapshot taken at frame end.
    always_comb begin
        sum_d  = sum_q;
        fsum_d = fsum_q;
        if (accept_s) begin
            sum_d = (tuser_q ? 32'd0 : sum_q) + 32'(tdata_q);
        end else begin
            sum_d = sum_q;
        end
        if (eof_s) begin
            fsum_d = sum_d;
        end else begin
            fsum_d = fsum_q;
        end
    end

    // Frame statistics registers.
    always_ff @(posedge ACLK or posedge reset) begin
        if (reset) begin
            sum_q  <= 32'd0;
            fsum_q <= 32'd0;
        end else begin
            sum_q  <= sum_d;
            fsum_q <= fsum_d;
        end
    end

    assign frame_sum = fsum_q;
`endif

endmodule

// File: tb/tb_vfp_axis_frame_source.sv
// Scoreboard bench for vfp_axis_frame_source: random frames and back-pressure,
// expected beats produced by an arithmetic pattern model.
module tb_vfp_axis_frame_source;

    localparam int DATA_W    = 8;
    localparam int NUM_CH    = 3;
    localparam int PPB       = 2;
    localparam int DIM_W     = 16;
    localparam int BAR_SHIFT = 1;
    localparam int CHK_SHIFT = 1;
    localparam int PIX_W     = DATA_W * NUM_CH;
    localparam int BEAT_W    = PIX_W * PPB;
    localparam int MAXV      = (1 << DATA_W) - 1;

    logic              ACLK, rst, enable, m_axis_tready;
    logic [1:0]        mode;
    logic [DIM_W-1:0]  h_beats, v_lines;
    logic [7:0]        h_blank;
    logic [PIX_W-1:0]  solid_color;
    logic              m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done;
    logic [BEAT_W-1:0] m_axis_tdata;
    logic [31:0]       frame_count;
`ifdef VFP_FRAME_SUM_EN
    logic [31:0]       frame_sum;
`endif

    vfp_axis_frame_source #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .PPB(PPB), .DIM_W(DIM_W),
        .BAR_SHIFT(BAR_SHIFT), .CHK_SHIFT(CHK_SHIFT)
    ) dut (
        .ACLK(ACLK), .reset(rst), .enable(enable), .mode(mode),
        .h_beats(h_beats), .v_lines(v_lines), .h_blank(h_blank),
        .solid_color(solid_color), .m_axis_tready(m_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .frame_done(frame_done), .frame_count(frame_count)
`ifdef VFP_FRAME_SUM_EN
        , .frame_sum(frame_sum)
`endif
    );

    typedef struct {
        logic [BEAT_W-1:0] data;
        logic              user;
        logic              last;
        logic              eof;
        int                hbl;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] sum_q[$];
    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int exp_count = 0;
    int ready_mode = 0;

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: condition not met at %0t", name, $time);
    endtask

    // Pattern rules written directly with integer arithmetic.
    function automatic logic [BEAT_W-1:0] model_beat(input int x, input int y, input int md,
                                                     input logic [PIX_W-1:0] sol);
        logic [BEAT_W-1:0] w;
        logic [PIX_W-1:0]  sh;
        int px, v, bar;
        w = '0;
        for (int p = 0; p < PPB; p++) begin
            px = x * PPB + p;
            for (int c = 0; c < NUM_CH; c++) begin
                case (md)
                    0: begin sh = sol >> (c * DATA_W); v = int'(sh) % (MAXV + 1); end
                    1: v = px % (MAXV + 1);
                    2: begin
                        bar = (px / (1 << BAR_SHIFT)) % 8;
                        v = (((bar >> (c % 3)) & 1) == 0) ? MAXV : 0;
                    end
                    default: v = ((((px >> CHK_SHIFT) + (y >> CHK_SHIFT)) % 2) == 1) ? MAXV : 0;
                endcase
                w[(p * NUM_CH + c) * DATA_W +: DATA_W] = DATA_W'(v);
            end
        end
        return w;
    endfunction

    task automatic push_frames(input int n, input int md, input int hb, input int vl,
                               input int hbl, input logic [PIX_W-1:0] sol);
        beat_t e;
        logic [31:0] s;
        for (int f = 0; f < n; f++) begin
            s = 32'd0;
            for (int y = 0; y < vl; y++) begin
                for (int x = 0; x < hb; x++) begin
                    e.data = model_beat(x, y, md, sol);
                    e.user = (x == 0 && y == 0);
                    e.last = (x == hb - 1);
                    e.eof  = (x == hb - 1 && y == vl - 1);
                    e.hbl  = hbl;
                    exp_q.push_back(e);
                    s = s + e.data[31:0];
                end
            end
            sum_q.push_back(s);
        end
    endtask

    task automatic wait_done(input int target, input string name);
        for (int i = 0; i < 3000 && done_seen < target; i++) begin
            @(negedge ACLK); #1;
        end
        if (done_seen < target) note_fail(name);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 100 && !m_axis_tvalid; i++) begin
            @(negedge ACLK); #1;
        end
        if (!m_axis_tvalid) note_fail("timeout_first_valid");
    endtask

    task automatic run_frames(input int n, input int md, input int hb, input int vl,
                              input int hbl, input logic [PIX_W-1:0] sol);
        int base;
        base        = done_seen;
        mode        = 2'(md);
        h_beats     = DIM_W'(hb);
        v_lines     = DIM_W'(vl);
        h_blank     = 8'(hbl);
        solid_color = sol;
        push_frames(n, md, hb, vl, hbl, sol);
        enable = 1'b1;
        wait_valid();
        wait_done(base + n - 1, "timeout_frames_before_last");
        enable      = 1'b0;
        mode        = 2'($urandom);
        h_beats     = DIM_W'($urandom_range(1, 9));
        v_lines     = DIM_W'($urandom_range(1, 9));
        h_blank     = 8'($urandom);
        solid_color = PIX_W'($urandom);
        wait_done(base + n, "timeout_last_frame");
        repeat (3) @(negedge ACLK);
        check("idle_after_frames", m_axis_tvalid, 1'b0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Sink back-pressure, changed just after each active edge.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge ACLK); #1;
            m_axis_tready = (ready_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks protocol rules.
    logic              have_hold, pending_done, gap_active;
    logic [BEAT_W-1:0] hold_data;
    logic              hold_user, hold_last;
    int                gap, exp_gap;
    beat_t             got;

    always @(negedge ACLK) begin
        if (rst) begin
            have_hold    = 1'b0;
            pending_done = 1'b0;
            gap_active   = 1'b0;
            exp_count    = 0;
        end else begin
            if (pending_done) begin
                check("frame_done_pulse", frame_done, 1'b1);
                pending_done = 1'b0;
            end else if (frame_done) begin
                note_fail("frame_done_unexpected");
            end
            if (frame_done) begin
                exp_count++;
                done_seen++;
                check("frame_count", frame_count, exp_count);
`ifdef VFP_FRAME_SUM_EN
                if (sum_q.size() == 0) note_fail("frame_sum_no_expectation");
                else check("frame_sum", frame_sum, sum_q.pop_front());
`endif
            end
            if (have_hold) begin
                check("stall_valid_held", m_axis_tvalid, 1'b1);
                check("stall_data_held", m_axis_tdata, hold_data);
                check("stall_user_held", m_axis_tuser, hold_user);
                check("stall_last_held", m_axis_tlast, hold_last);
            end
            if (gap_active) begin
                if (m_axis_tvalid) begin
                    check("hblank_idle_cycles", gap, exp_gap);
                    gap_active = 1'b0;
                end else begin
                    gap++;
                    if (gap > 300) begin
                        note_fail("hblank_timeout");
                        gap_active = 1'b0;
                    end
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                have_hold = 1'b0;
                if (exp_q.size() == 0) begin
                    note_fail("unexpected_beat");
                end else begin
                    got = exp_q.pop_front();
                    check("tdata", m_axis_tdata, got.data);
                    check("tuser", m_axis_tuser, got.user);
                    check("tlast", m_axis_tlast, got.last);
                    if (got.eof) begin
                        pending_done = 1'b1;
                    end else if (got.last) begin
                        gap_active = 1'b1;
                        gap        = 0;
                        exp_gap    = got.hbl;
                    end
                end
            end else if (m_axis_tvalid) begin
                have_hold = 1'b1;
                hold_data = m_axis_tdata;
                hold_user = m_axis_tuser;
                hold_last = m_axis_tlast;
            end else begin
                have_hold = 1'b0;
            end
        end
    end

    logic bad;

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 2'd0;
        h_beats = 16'd4; v_lines = 16'd2; h_blank = 8'd2; solid_color = 24'd0;
        repeat (2) @(negedge ACLK);
        check("reset_tvalid", m_axis_tvalid, 1'b0);
        check("reset_tuser", m_axis_tuser, 1'b0);
        check("reset_tlast", m_axis_tlast, 1'b0);
        check("reset_frame_done", frame_done, 1'b0);
        check("reset_frame_count", frame_count, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge ACLK);
        check("no_beats_without_enable", m_axis_tvalid, 1'b0);

        // Directed: ramp with blanking, bars without blanking, checker back-to-back, solid.
        run_frames(1, 1, 4, 2, 2, 24'h000000);
        run_frames(1, 2, 4, 2, 0, 24'h000000);
        run_frames(2, 3, 3, 4, 1, 24'h000000);
        run_frames(1, 0, 4, 2, 2, 24'h000001);

        // Random frames under random back-pressure.
        ready_mode = 1;
        for (int i = 0; i < 14; i++) begin
            run_frames($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(1, 6),
                       $urandom_range(1, 4), $urandom_range(0, 3), PIX_W'($urandom));
        end

        // Asynchronous reset in the middle of a line.
        mode = 2'd1; h_beats = 16'd5; v_lines = 16'd3; h_blank = 8'd1;
        push_frames(1, 1, 5, 3, 1, 24'd0);
        enable = 1'b1;
        wait_valid();
        repeat (3) @(posedge ACLK);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_tvalid", m_axis_tvalid, 1'b0);
        check("async_reset_tuser", m_axis_tuser, 1'b0);
        check("async_reset_tlast", m_axis_tlast, 1'b0);
        check("async_reset_frame_count", frame_count, 32'd0);
        exp_q.delete();
        sum_q.delete();
        enable = 1'b0;
        repeat (2) @(negedge ACLK);
        rst = 1'b0;

        // Zero geometry never starts a frame.
        h_beats = 16'd0; v_lines = 16'd3; enable = 1'b1; bad = 1'b0;
        repeat (20) begin @(negedge ACLK); if (m_axis_tvalid) bad = 1'b1; end
        check("no_beats_h_beats_zero", bad, 1'b0);
        h_beats = 16'd4; v_lines = 16'd0; bad = 1'b0;
        repeat (20) begin @(negedge ACLK); if (m_axis_tvalid) bad = 1'b1; end
        check("no_beats_v_lines_zero", bad, 1'b0);
        enable = 1'b0;
        @(negedge ACLK);

        // Counting restarts from zero after reset.
        run_frames(1, 2, 5, 2, 3, 24'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vfp_axis_frame_source.md
Name: vfp_axis_frame_source

Overview:
Parametrised AXI4-Stream video frame generator that replaces the fixed 24-bit RGB camera source in the VFP bench and design path.
- Generalised in channel count, channel width and pixels per beat.
- Adds runtime-selectable test patterns, programmable frame geometry, horizontal blanking and frame statistics.
- Drives the rgb_s_axis input of the VFP pipeline, or any AXI4-Stream video sink.

Parameters:
DATA_W, 8, bits per colour channel
NUM_CH, 3, colour channels per pixel (channel 0 in LSBs)
PPB, 1, pixels per beat (pixel 0 in LSBs)
DIM_W, 16, width of geometry counters/ports
BAR_SHIFT, 5, log2 of colour-bar width in pixels
CHK_SHIFT, 3, log2 of checker square size in pixels

Ports:
ACLK  in  1  clock
reset  in  1  asynchronous active-high reset
enable  in  1  start/continue frame generation
mode  in  2  0 solid, 1 ramp, 2 colour bars, 3 checker
h_beats  in  DIM_W  active beats per line
v_lines  in  DIM_W  active lines per frame
h_blank  in  8  idle cycles after each line
solid_color  in  DATA_W*NUM_CH  pixel value for mode 0
m_axis_tready  in  1  sink ready
m_axis_tvalid  out  1  beat valid
m_axis_tdata  out  DATA_W*NUM_CH*PPB  pixel data
m_axis_tuser  out  1  start of frame (first beat only)
m_axis_tlast  out  1  end of line
frame_done  out  1  one-cycle pulse after last beat of a frame is accepted
frame_count  out  32  completed frames, wraps

Behaviour:
- Reset is asynchronous and active-high. ACLK is the only clock. All outputs, counters and the FSM are cleared to 0/IDLE on reset assertion, including mid-line. No beats are generated until enable is sampled high after reset release.
- FSM states:
  - IDLE: go to LINE when enable=1 and h_beats!=0 and v_lines!=0. mode, h_beats, v_lines, h_blank and solid_color are latched on this transition and held for the whole frame.
  - LINE: tvalid=1. Advance x_beat on each tvalid&&tready. At the last beat (x_beat==h_beats-1), tlast=1. When it is accepted, go to HBLANK if h_blank!=0. Otherwise go straight to the next line, or end of frame.
  - HBLANK: tvalid=0 for exactly h_blank cycles, then LINE with y+1.
  - End of frame = last beat of line v_lines-1 accepted. frame_done pulses the following cycle and frame_count increments. Next state: LINE with new latched config if enable=1, else IDLE. There is no vertical blank.
- Handshake:
  - While tvalid=1 and tready=0, tdata/tuser/tlast are held stable.
  - tvalid is never withdrawn before acceptance.
  - tvalid asserts one cycle after leaving IDLE; output is registered, latency 1.
- tuser=1 only on beat x=0, y=0.
- enable deasserted mid-frame: the current frame completes, then IDLE. No truncated frames.
- Pixel coordinate px = x_beat*PPB + p for p in 0..PPB-1. py = line index.
- Patterns, per channel c:
  - solid: solid_color slice c.
  - ramp: px[DATA_W-1:0], wrapping.
  - bars: b = px>>BAR_SHIFT (3 LSBs). Value = all-ones if b[c mod 3]==0, else 0. Bar 0 is white, bar 7 black; the sequence repeats.
  - checker: all-ones if ((px>>CHK_SHIFT)^(py>>CHK_SHIFT)) LSB is 1, else 0.
- Counter widths: x/y DIM_W, blank counter 8, frame_count 32 wrapping from 0xFFFFFFFF to 0.

Optional Feature:
VFP_FRAME_SUM_EN:
- Defined: adds output frame_sum[31:0].
  - A 32-bit modular running sum of all accepted tdata words, each zero-extended or truncated to 32 bits.
  - The running sum is cleared at the tuser beat.
  - frame_sum is latched in the same cycle frame_done pulses and reset to 0.
- Undefined: the port and logic are absent. The rest of the block is unchanged.

Decomposition:
- Package vfp_src_pkg holds:
  - enum src_state_e {IDLE, LINE, HBLANK}
  - enum pattern_e {PAT_SOLID, PAT_RAMP, PAT_BARS, PAT_CHECK}
  - default parameter constants
- One sub-module, vfp_pattern_pixel: combinational per-pixel colour from mode, px, py and solid_color. It is instantiated PPB times by generate.

Test Plan:
1. DATA_W=8, NUM_CH=3, PPB=1, h_beats=4, v_lines=2, h_blank=2, mode=ramp, tready=1 -> beats 0x000000, 0x010101, 0x020202, 0x030303 per line. tuser only on beat 0. tlast on beats 3 and 7. Exactly 2 idle cycles between lines. frame_done pulses once and frame_count=1.
2. Same setup, tready low for 3 cycles at beat 2 -> tdata stays 0x020202 with tvalid=1 throughout, no beat lost or duplicated.
3. h_blank=0, PPB=2, mode=bars, BAR_SHIFT=1 -> continuous tvalid across lines. First beat tdata=0xFFFFFF_FFFFFF (bar 0 white), second beat pixels both bar 1 = 0xFFFF00_FFFF00.
4. enable dropped at beat 1 of line 0 -> full 8-beat frame completes, then IDLE with tvalid=0. frame_count=1.
5. reset asserted mid-line (asynchronous, between edges) -> tvalid, tuser, tlast and frame_count go 0 immediately. h_beats=0 with enable=1 -> stays in IDLE, no beats.
6. With VFP_FRAME_SUM_EN, test 1 config, mode=solid, solid_color=0x000001 -> frame_sum=8 at frame_done.
